// File: rtl/sig_settle_pkg.sv
// Shared types and constants for the settle qualifier.
// No logic of its own; state enum, default constants and a counter-width helper.
// Imported by sig_settle_qualifier.
package sig_settle_pkg;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_SETTLING = 1'b1
   } state_t;

   localparam int SETTLE_DEF   = 4;
   localparam int MAX_WAIT_DEF = 64;

   // Bits needed to hold values 0..limit inclusive.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/sig_settle_qualifier.sv
// Commits a synchronized multi-bit word only after SETTLE identical consecutive samples.
// Latency: SETTLE cycles from first sample of a new value to settled_out/new_val (registered).
// No backpressure; optional SIG_SETTLE_ERR_EN adds a sticky timeout flag (unstable_err/err_clr).
module sig_settle_qualifier
   import sig_settle_pkg::*;
#(
   parameter int N        = 24,
   parameter int SETTLE   = SETTLE_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic         clkin,
   input  logic         reset_n,
   input  logic [N-1:0] synced_sig_in,
   output logic [N-1:0] settled_out,
   output logic         new_val,
   output logic         busy
`ifdef SIG_SETTLE_ERR_EN
   ,
   input  logic         err_clr,
   output logic         unstable_err
`endif
);

   localparam int            CW   = cnt_width(SETTLE);
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   state_t        r_state;
   logic [N-1:0]  r_cand;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_out;
   logic          r_new;

   state_t        w_state_nxt;
   logic [N-1:0]  w_cand_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [N-1:0]  w_out_nxt;
   logic          w_new_nxt;
   logic          w_enter;

   // Next-state and datapath decisions; every target defaults to holding its value.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      w_new_nxt   = 1'b0;
      w_enter     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (synced_sig_in != r_out) begin
               w_cand_nxt  = synced_sig_in;
               w_cnt_nxt   = CW'(1);
               w_state_nxt = ST_SETTLING;
               w_enter     = 1'b1;
            end
         end
         ST_SETTLING: begin
            if (synced_sig_in == r_cand) begin
               if (r_cnt == LAST) begin
                  // Commit; a candidate equal to the held word was a glitch that reverted.
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  if (r_cand != r_out) begin
                     w_out_nxt = r_cand;
                     w_new_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else begin
               // Any change restarts stability with the new sample counted as the first.
               w_cand_nxt = synced_sig_in;
               w_cnt_nxt  = CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, candidate, counter and registered outputs.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_new   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_out_nxt;
         r_new   <= w_new_nxt;
      end
   end

   assign settled_out = r_out;
   assign new_val     = r_new;
   assign busy        = (r_state == ST_SETTLING);

`ifdef SIG_SETTLE_ERR_EN
   localparam int            WW       = cnt_width(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WAIT_PRE = WW'(MAX_WAIT - 1);

   logic [WW-1:0] r_wait;
   logic          r_err;
   logic          w_err_set;

   // Flag is raised on the edge where the timer reaches its ceiling, not while it sits there.
   assign w_err_set = (r_state == ST_SETTLING) && (r_wait == WAIT_PRE);

   // Wait timer: cleared on entry to SETTLING, saturating count of SETTLING cycles.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         r_wait <= '0;
      end else if (w_enter) begin
         r_wait <= '0;
      end else if ((r_state == ST_SETTLING) && (r_wait != WAIT_MAX)) begin
         r_wait <= r_wait + WW'(1);
      end
   end

   // Sticky error; a set in the same cycle as a clear takes priority.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign unstable_err = r_err;
`else
   localparam int unused_max_wait = MAX_WAIT;
`endif

endmodule
